// File: rtl/op_trans_pkg.sv
// Shared types and helpers for the row packer that feeds the transpose stage.
package op_trans_pkg;

    // Packer state: gathering rows, or holding a complete matrix for downstream.
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Width of one row on the input stream (COLS elements of DATA_WIDTH bits).
    function automatic int row_width(input int cols, input int data_width);
        return cols * data_width;
    endfunction

endpackage

// File: rtl/matrix_row_slot.sv
// One row slot of the packed matrix: a row-wide register with write enable
// and asynchronous clear.
module matrix_row_slot #(
    parameter int ROW_W = 8
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_data,
    output logic [ROW_W-1:0] slot_data
);

    logic [ROW_W-1:0] slot_reg;

    // Capture the incoming row when this slot is addressed; hold otherwise.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg <= '0;
        end else if (wr_en) begin
            slot_reg <= wr_data;
        end
    end

    assign slot_data = slot_reg;

endmodule

// File: rtl/matrix_row_packer.sv
// Row-serial to full-matrix packer. Rows arrive one per beat and are written
// into per-row slots; once the last row lands the whole matrix is presented
// with a valid/ready handshake to the transpose stage.
module matrix_row_packer
    import op_trans_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 128,
    parameter int COLS       = 768,
    parameter int CNT_W      = $clog2(ROWS + 1)
) (
    input  logic                            clk_p,
    input  logic                            rst_n,
    input  logic [COLS*DATA_WIDTH-1:0]      row_data,
    input  logic                            row_valid,
    input  logic                            row_last,
    output logic                            row_ready,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] matrix,
    output logic                            matrix_valid,
    input  logic                            matrix_ready,
    output logic [CNT_W-1:0]                row_count,
    output logic                            err_len
);

    localparam int ROW_W = row_width(COLS, DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] row_count_reg;
    logic             matrix_valid_reg;
    logic             err_len_reg;
    logic             row_accept;
    logic             at_last_row;

    // row_ready comes straight from the state register so there is no
    // combinational path from matrix_ready back to the producer.
    assign row_ready   = (state_reg == COLLECT);
    assign row_accept  = row_valid && row_ready;
    assign at_last_row = (row_count_reg == LAST_ROW);

    // One slot per matrix row; the slot addressed by row_count takes the row.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_slot
            logic slot_wr_en;

            assign slot_wr_en = row_accept && (row_count_reg == CNT_W'(gi));

            matrix_row_slot #(
                .ROW_W (ROW_W)
            ) u_slot (
                .clk_p     (clk_p),
                .rst_n     (rst_n),
                .wr_en     (slot_wr_en),
                .wr_data   (row_data),
                .slot_data (matrix[gi*ROW_W +: ROW_W])
            );
        end
    endgenerate

    // Frame FSM: counts accepted rows, flags length errors, and holds the
    // matrix until downstream takes it.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= COLLECT;
            row_count_reg    <= '0;
            matrix_valid_reg <= 1'b0;
            err_len_reg      <= 1'b0;
        end else begin
            err_len_reg <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    if (row_accept) begin
                        if (at_last_row) begin
                            // Final row: frame is complete even if row_last
                            // was missing, which is only reported.
                            state_reg        <= FULL;
                            matrix_valid_reg <= 1'b1;
                            row_count_reg    <= '0;
                            err_len_reg      <= ~row_last;
                        end else if (row_last) begin
                            // Short frame: drop it and start over.
                            row_count_reg <= '0;
                            err_len_reg   <= 1'b1;
                        end else begin
                            row_count_reg <= row_count_reg + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (matrix_ready) begin
                        state_reg        <= COLLECT;
                        matrix_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= COLLECT;
                    matrix_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign matrix_valid = matrix_valid_reg;
    assign row_count    = row_count_reg;
    assign err_len      = err_len_reg;

endmodule
